clktick_multi: RTL and testbench

- Multi-channel programmable tick generator and parametrised successor to the single-channel clock divider.
- Provides CH independent divide-by-(N+1) tick channels. Each channel has its own runtime-written period, a periodic or one-shot mode, per-channel enable and restart.
- Feeds FSM timing, LED sequencing and delay generation across the lab designs from a single shared block.

---
 rtl/clktick_multi.sv | 102 ++++++++++
 tb/tb_clktick_multi.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/clktick_multi.sv
// clktick_multi: CH independent divide-by-(N+1) tick channels, periodic or one-shot, with per-channel enable/restart.
// Optional per-channel tick counters on tick_cnt when CLKTICK_TICKCNT_EN is defined.
module clktick_multi #(
  parameter int CH = 4,
  parameter int N_WIDTH = 16,
  parameter int CNT_WIDTH = 8,
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CH-1:0]        ch_en,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [N_WIDTH-1:0]   wr_n,
  input  logic                 wr_oneshot,
  input  logic [CH-1:0]        restart,
  output logic [CH-1:0]        tick,
  output logic [CH-1:0]        busy
`ifdef CLKTICK_TICKCNT_EN
  , output logic [CH*CNT_WIDTH-1:0] tick_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q [CH];
  state_t             state_d [CH];
  logic [N_WIDTH-1:0] period_q [CH];
  logic [N_WIDTH-1:0] period_d [CH];
  logic [N_WIDTH-1:0] count_q [CH];
  logic [N_WIDTH-1:0] count_d [CH];
  logic [CH-1:0]      mode_q, mode_d, tick_q, tick_d, wr_hit;
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign wr_hit[g] = wr_en && (wr_ch == CH_W'(g));
    assign busy[g]   = state_q[g] == RUN;
  end
  assign tick = tick_q;
  // Per channel priority: write, then restart, then advance.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      count_d[i]  = count_q[i];
      mode_d[i]   = mode_q[i];
      tick_d[i]   = 1'b0;
      if (wr_hit[i]) begin
        period_d[i] = wr_n;
        mode_d[i]   = wr_oneshot;
        count_d[i]  = wr_n;
        state_d[i]  = RUN;
      end else if (restart[i]) begin
        count_d[i] = period_q[i];
        state_d[i] = RUN;
      end else if (en && ch_en[i] && state_q[i] == RUN) begin
        if (count_q[i] != '0) count_d[i] = count_q[i] - 1'b1;
        else begin
          tick_d[i]  = 1'b1;
          count_d[i] = mode_q[i] ? count_q[i] : period_q[i];
          state_d[i] = mode_q[i] ? DONE : RUN;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= IDLE;
        period_q[i] <= '0;
        count_q[i]  <= '0;
      end
      mode_q <= '0;
      tick_q <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
    end
  end
`ifdef CLKTICK_TICKCNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [CH];
  logic [CNT_WIDTH-1:0] cnt_d [CH];
  always_comb begin
    for (int i = 0; i < CH; i++)
      cnt_d[i] = wr_hit[i] ? '0 : cnt_q[i] + CNT_WIDTH'(tick_d[i]);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign tick_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`else
  // CNT_WIDTH only sizes the optional counters.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_WIDTH;
`endif
endmodule

// File: tb/tb_clktick_multi.sv
// tb_clktick_multi: directed checks of clktick_multi on a 4-channel and a 3-channel instance.
module tb_clktick_multi;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, wr_en = 1'b0, wr_oneshot = 1'b0;
  logic [3:0]  ch_en = 4'h0, restart = 4'h0, tick, busy;
  logic [1:0]  wr_ch = 2'd0;
  logic [15:0] wr_n = 16'd0;
  logic        en3 = 1'b0, wr_en3 = 1'b0, wr_oneshot3 = 1'b0;
  logic [2:0]  ch_en3 = 3'h0, restart3 = 3'h0, tick3, busy3;
  logic [1:0]  wr_ch3 = 2'd0;
  logic [15:0] wr_n3 = 16'd0;
`ifdef CLKTICK_TICKCNT_EN
  logic [31:0] tick_cnt;
  logic [23:0] tick_cnt3;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clktick_multi #(.CH(4), .N_WIDTH(16), .CNT_WIDTH(8)) u4 (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_n(wr_n), .wr_oneshot(wr_oneshot), .restart(restart), .tick(tick), .busy(busy)
`ifdef CLKTICK_TICKCNT_EN
    , .tick_cnt(tick_cnt)
`endif
  );

  clktick_multi #(.CH(3), .N_WIDTH(16), .CNT_WIDTH(8)) u3 (
    .clk(clk), .rst(rst), .en(en3), .ch_en(ch_en3), .wr_en(wr_en3), .wr_ch(wr_ch3),
    .wr_n(wr_n3), .wr_oneshot(wr_oneshot3), .restart(restart3), .tick(tick3), .busy(busy3)
`ifdef CLKTICK_TICKCNT_EN
    , .tick_cnt(tick_cnt3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_busy3", 32'(busy3), 32'h0);
    cyc(1);
    rst = 1'b1;
    en = 1'b1; ch_en = 4'hF; en3 = 1'b1; ch_en3 = 3'h7;
    cyc(1);
    check("idle_busy", 32'(busy), 32'h0);
    // periodic ch0 N=3
    wr_en = 1'b1; wr_ch = 2'd0; wr_n = 16'd3; wr_oneshot = 1'b0;
    cyc(1);
    wr_en = 1'b0;
    check("per_busy_wr", 32'(busy), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      check($sformatf("per_tick_k%0d", k), 32'(tick), (k % 4 == 0) ? 32'h1 : 32'h0);
      check($sformatf("per_busy_k%0d", k), 32'(busy), 32'h1);
    end
    // minimum period ch1 N=0
    wr_en = 1'b1; wr_ch = 2'd1; wr_n = 16'd0;
    cyc(1);
    wr_en = 1'b0;
    check("min_wr_tick1", 32'(tick[1]), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check($sformatf("min_tick1_k%0d", k), 32'(tick[1]), 32'h1);
    end
`ifdef CLKTICK_TICKCNT_EN
    check("cnt1_5", 32'(tick_cnt[15:8]), 32'd5);
    cyc(251);
    check("cnt1_wrap", 32'(tick_cnt[15:8]), 32'd0);
    check("cnt1_wrap_tick", 32'(tick[1]), 32'h1);
`endif
    // one-shot ch2 N=5 then restart
    wr_en = 1'b1; wr_ch = 2'd2; wr_n = 16'd5; wr_oneshot = 1'b1;
    cyc(1);
    wr_en = 1'b0; wr_oneshot = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      cyc(1);
      check($sformatf("os_tick2_k%0d", k), 32'(tick[2]), (k == 6) ? 32'h1 : 32'h0);
      check($sformatf("os_busy2_k%0d", k), 32'(busy[2]), (k < 6) ? 32'h1 : 32'h0);
    end
    restart = 4'b0100;
    cyc(1);
    restart = 4'h0;
    check("rs_busy2", 32'(busy[2]), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      check($sformatf("rs_tick2_k%0d", k), 32'(tick[2]), (k == 6) ? 32'h1 : 32'h0);
    end
    // global enable gating on ch0
    wr_en = 1'b1; wr_ch = 2'd0; wr_n = 16'd3;
    cyc(1);
    wr_en = 1'b0;
    cyc(2);
    en = 1'b0;
    for (int k = 3; k <= 4; k++) begin
      cyc(1);
      check($sformatf("en_off_tick_k%0d", k), 32'(tick), 32'h0);
    end
    en = 1'b1;
    for (int k = 5; k <= 10; k++) begin
      cyc(1);
      check($sformatf("en_tick0_k%0d", k), 32'(tick[0]), (k == 6 || k == 10) ? 32'h1 : 32'h0);
    end
    // ch_en[0] gating while ch3 keeps ticking
    wr_en = 1'b1; wr_ch = 2'd3; wr_n = 16'd1;
    cyc(1);
    wr_ch = 2'd0; wr_n = 16'd3;
    cyc(1);
    wr_en = 1'b0;
    for (int j = 2; j <= 12; j++) begin
      if (j == 3) ch_en = 4'hE;
      if (j == 5) ch_en = 4'hF;
      cyc(1);
      check($sformatf("chen_tick0_j%0d", j), 32'(tick[0]), (j == 7 || j == 11) ? 32'h1 : 32'h0);
      check($sformatf("chen_tick3_j%0d", j), 32'(tick[3]), (j % 2 == 0) ? 32'h1 : 32'h0);
    end
    // collisions on CH=3: write beats restart, out-of-range write ignored
    wr_en3 = 1'b1; wr_ch3 = 2'd1; wr_n3 = 16'd7; restart3 = 3'b010;
    cyc(1);
    wr_en3 = 1'b0; restart3 = 3'h0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 10) begin
        wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_n3 = 16'd0; wr_oneshot3 = 1'b1;
      end
      if (k == 11) begin
        wr_en3 = 1'b0; wr_oneshot3 = 1'b0;
      end
      cyc(1);
      check($sformatf("col_tick3_k%0d", k), 32'(tick3), (k == 8 || k == 16) ? 32'h2 : 32'h0);
      check($sformatf("col_busy3_k%0d", k), 32'(busy3), 32'h2);
    end
    // asynchronous reset mid-cycle
    #2;
    check("pre_rst_tick1", 32'(tick[1]), 32'h1);
    rst = 1'b0;
    #1;
    check("async_tick", 32'(tick), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_busy3", 32'(busy3), 32'h0);
`ifdef CLKTICK_TICKCNT_EN
    check("async_cnt", tick_cnt, 32'h0);
`endif
    #1;
    rst = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      cyc(1);
      check($sformatf("post_rst_tick_k%0d", k), {28'h0, tick}, 32'h0);
      check($sformatf("post_rst_busy_k%0d", k), {28'h0, busy}, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
